reg_bank_ctrl: RTL and testbench
================================

// Module: reg_bank_ctrl
// PURPOSE
//  Parametrised register bank behind a sel/wr/ready slave port; successor of the single-width ctrl-register block.
//  Adds byte-enable writes, configurable read latency, a read-only address window and an error response.
//  Sits between the bus bridge and the block-level control/status registers.
// PARAMETERS
//  ADDR_WIDTH  8        address bus width
//  DATA_WIDTH  32       register width; must be a multiple of 8
//  DEPTH       256      implemented registers; valid addresses are 0..DEPTH-1, with DEPTH <= 2**ADDR_WIDTH
//  RD_LATENCY  2        accepting edge to rvalid, in clock edges; legal range 1..4
//  RESET_VAL   32'h0    reset value of every register
//  RO_START    DEPTH    first read-only address; RO_START >= DEPTH disables the window
//  RO_END      DEPTH    last read-only address, inclusive
// PORTS
//  clk     in   1              clock
//  rstn    in   1              reset; synchronous, active-low
//  sel     in   1              transfer request
//  wr      in   1              1 = write, 0 = read
//  addr    in   ADDR_WIDTH     register address
//  wdata   in   DATA_WIDTH     write data
//  be      in   DATA_WIDTH/8   byte enables; bit i selects wdata[8i+7:8i]
//  ready   out  1              slave can accept a transfer this cycle
//  rvalid  out  1              rdata valid; one-cycle pulse
//  rdata   out  DATA_WIDTH     read data; forced to 0 whenever rvalid is 0
//  err     out  1              error response; one-cycle pulse
// BEHAVIOUR
//  Reset (sampled at clk edge with rstn=0):
//   - ready=1, rvalid=0, rdata=0, err=0; all registers = RESET_VAL; FSM -> IDLE.
//   - Any outstanding read is aborted; no rvalid is ever produced for it.
//  Accept: a transfer is accepted on an edge where sel & ready = 1. At most one transfer per edge.
//  Write:
//   - Takes effect at the accepting edge; only bytes with be[i]=1 are updated.
//   - ready stays 1, so back-to-back writes run at one per cycle.
//   - If addr >= DEPTH or RO_START <= addr <= RO_END: no register changes, and err=1 for the following cycle.
//   - be=0 on a legal address: no change, err=0.
//  Read: FSM with states IDLE and RD_WAIT.
//   - IDLE -> RD_WAIT on read accept when RD_LATENCY > 1.
//   - A down-counter loads RD_LATENCY-1 and decrements each edge.
//   - RD_WAIT -> IDLE on the edge where the counter expires; that edge also registers rvalid=1, rdata and err.
//   - RD_LATENCY=1: no RD_WAIT; rvalid and rdata are registered at the accepting edge.
//   - rdata is the register value as of the accepting edge (snapshot).
//   - ready=0 from the accepting edge until the rvalid edge, which sets ready=1.
//     Net effect: ready and rvalid are both high in the same cycle, allowing the next accept there.
//   - Out-of-range read: rvalid=1, rdata=0, err=1 at the same latency. Reads inside the RO window are legal.
//   - sel, wr and addr are ignored while in RD_WAIT.
//  Read-after-write: a read accepted the cycle after a write returns the new data.
//  An addr upper-bit aliasing the range 0..DEPTH-1 is not permitted; decode uses the full addr.
// STRUCTURE
//  Package reg_bank_pkg:
//   - typedef enum logic {IDLE, RD_WAIT} rb_state_t;
//   - function byte_merge(old, wdata, be), shared by the RTL and the bench model.
//  Sub-module reg_bank_mem:
//   - Storage array with byte-enable write port, combinational read and synchronous reset to RESET_VAL.
//   - The top level holds the FSM, latency counter, address/RO decode and output registers.
//  Elaboration-time assertions: DATA_WIDTH%8==0, 1<=RD_LATENCY<=4, DEPTH<=2**ADDR_WIDTH.
// TESTING
//  1. Reset, then read addr 0x10 with RD_LATENCY=2 -> rvalid 2 edges after accept, rdata=RESET_VAL, ready low for 1 cycle.
//  2. Write 0xAABBCCDD to 0x05 with be=4'b0101 over 0x11223344, then read -> rdata=0x11BB33DD, err=0.
//  3. DEPTH=16: write to addr 0x20 -> err pulse, no register change.
//     Then read 0x20 -> rvalid=1, rdata=0, err=1.
//  4. RO_START=4, RO_END=7: write 0xFFFF_FFFF to 6 -> err=1, and a later read of 6 returns RESET_VAL with err=0.
//  5. RD_LATENCY=1: back-to-back reads of 1,2,3 on consecutive edges.
//     Expect rvalid high for 3 cycles with matching data; ready stays 1 throughout.
//  6. Accept a read with RD_LATENCY=4, assert rstn=0 one edge later -> no rvalid ever; ready=1, registers=RESET_VAL after reset.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the register bank.
// Latency: n/a. Backpressure: n/a.
package reg_bank_pkg;

    typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} rb_state_t;

    // Widest register the merge helper supports; callers extend/truncate to their width.
    localparam int RB_MAX_DW = 128;
    localparam int RB_MAX_BE = RB_MAX_DW / 8;

    function automatic logic [RB_MAX_DW-1:0] byte_merge(
        input logic [RB_MAX_DW-1:0] old_val,
        input logic [RB_MAX_DW-1:0] new_val,
        input logic [RB_MAX_BE-1:0] be
    );
        logic [RB_MAX_DW-1:0] res;
        res = old_val;
        for (int i = 0; i < RB_MAX_BE; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_bank_mem.sv
// Register storage: byte-enable write port, combinational read, sync reset to RESET_VAL.
// Latency: write lands at the clock edge, read is combinational. Backpressure: none.
module reg_bank_mem
    import reg_bank_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  DEPTH      = 256,
    parameter int                  IW         = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    we,
    input  logic [IW-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [IW-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [RB_MAX_DW-1:0]  merged;

    always_comb begin
        merged = byte_merge(RB_MAX_DW'(mem[waddr]), RB_MAX_DW'(wdata), RB_MAX_BE'(be));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
        end else if (we) begin
            mem[waddr] <= merged[DATA_WIDTH-1:0];
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/reg_bank_ctrl.sv
// Register bank slave: sel/wr port, byte-enable writes, RO window, error response.
// Latency: writes at the accepting edge; reads return RD_LATENCY edges after accept.
// Backpressure: ready drops for the duration of a multi-cycle read, otherwise stays high.
module reg_bank_ctrl
    import reg_bank_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter int                    RD_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
    parameter int                    RO_START   = DEPTH,
    parameter int                    RO_END     = DEPTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sel,
    input  logic                    wr,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic                    ready,
    output logic                    rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    err
);

    localparam int         IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] CNT_LOAD = 3'(RD_LATENCY - 1);

    if (DATA_WIDTH % 8 != 0)                        begin : g_chk_dw  $error("DATA_WIDTH must be a multiple of 8"); end
    if (DATA_WIDTH > RB_MAX_DW)                     begin : g_chk_max $error("DATA_WIDTH exceeds byte_merge width"); end
    if (RD_LATENCY < 1 || RD_LATENCY > 4)           begin : g_chk_lat $error("RD_LATENCY must be 1..4"); end
    if (64'(DEPTH) > (64'd1 << ADDR_WIDTH))         begin : g_chk_dep $error("DEPTH exceeds address space"); end

    rb_state_t             state;
    logic [2:0]            cnt;
    logic [DATA_WIDTH-1:0] hold_dat;
    logic                  hold_err;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  accept;
    logic                  in_range;
    logic                  ro_hit;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] rd_val;

    // Full-width decode: upper address bits never alias onto implemented registers.
    assign in_range = 32'(addr) < DEPTH;
    assign ro_hit   = (32'(addr) >= RO_START) && (32'(addr) <= RO_END);
    assign wr_ok    = in_range && !ro_hit;
    assign accept   = sel && ready;
    assign rd_val   = in_range ? mem_rdata : '0;

    reg_bank_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IW         (IW),
        .RESET_VAL  (RESET_VAL)
    ) u_mem (
        .clk   (clk),
        .rstn  (rstn),
        .we    (accept && wr && wr_ok),
        .waddr (addr[IW-1:0]),
        .wdata (wdata),
        .be    (be),
        .raddr (addr[IW-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            ready    <= 1'b1;
            rvalid   <= 1'b0;
            rdata    <= '0;
            err      <= 1'b0;
            hold_dat <= '0;
            hold_err <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (wr) begin
                            err <= !wr_ok;
                        end else if (RD_LATENCY == 1) begin
                            rvalid <= 1'b1;
                            rdata  <= rd_val;
                            err    <= !in_range;
                        end else begin
                            // Snapshot now; the bank cannot change while ready is low.
                            state    <= RD_WAIT;
                            cnt      <= CNT_LOAD;
                            ready    <= 1'b0;
                            hold_dat <= rd_val;
                            hold_err <= !in_range;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == 3'd1) begin
                        state  <= IDLE;
                        ready  <= 1'b1;
                        rvalid <= 1'b1;
                        rdata  <= hold_dat;
                        err    <= hold_err;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Bench for reg_bank_ctrl: three instances (latency 2 / latency 1 with RO window / latency 4),
// scoreboard queues checked by a negedge monitor, plus table vectors and timing sequences.
module tb_reg_bank_ctrl;

    localparam logic [31:0] RV_A = 32'h1234_5678;
    localparam logic [31:0] RV_B = 32'hDEAD_BEEF;
    localparam logic [31:0] RV_C = 32'h0BAD_F00D;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sel    [3];
    logic        wr     [3];
    logic [7:0]  addr   [3];
    logic [31:0] wdata  [3];
    logic [3:0]  be     [3];
    logic        ready  [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic        err    [3];

    always #5 clk = ~clk;

    reg_bank_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256), .RD_LATENCY(2),
                    .RESET_VAL(RV_A)) u_dut_a (
        .clk(clk), .rstn(rstn), .sel(sel[0]), .wr(wr[0]), .addr(addr[0]), .wdata(wdata[0]),
        .be(be[0]), .ready(ready[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .err(err[0]));

    reg_bank_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .RD_LATENCY(1),
                    .RESET_VAL(RV_B), .RO_START(4), .RO_END(7)) u_dut_b (
        .clk(clk), .rstn(rstn), .sel(sel[1]), .wr(wr[1]), .addr(addr[1]), .wdata(wdata[1]),
        .be(be[1]), .ready(ready[1]), .rvalid(rvalid[1]), .rdata(rdata[1]), .err(err[1]));

    reg_bank_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .RD_LATENCY(4),
                    .RESET_VAL(RV_C)) u_dut_c (
        .clk(clk), .rstn(rstn), .sel(sel[2]), .wr(wr[2]), .addr(addr[2]), .wdata(wdata[2]),
        .be(be[2]), .ready(ready[2]), .rvalid(rvalid[2]), .rdata(rdata[2]), .err(err[2]));

    typedef struct packed {
        logic        rv;
        logic [31:0] rd;
        logic        er;
    } exp_t;

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [3:0]  b;
        logic        out;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Scoreboard monitor: every rvalid/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (!rvalid[d] && rdata[d] !== 32'h0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dut%0d_rdata_idle: got %h while rvalid=0, expected 0", d, rdata[d]);
            end
            if (rvalid[d] || err[d]) begin
                if (qsize(d) == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dut%0d_unexpected_resp: got rvalid=%b err=%b, expected no response",
                             d, rvalid[d], err[d]);
                end else begin
                    e = qpop(d);
                    chk($sformatf("dut%0d_rvalid", d), 32'(rvalid[d]), 32'(e.rv));
                    chk($sformatf("dut%0d_rdata", d), rdata[d], e.rd);
                    chk($sformatf("dut%0d_err", d), 32'(err[d]), 32'(e.er));
                end
            end
        end
    end

    // Drive one transfer, wait (bounded) for ready, return 1ns after the accepting edge.
    task automatic drv(input int d, input logic w, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input logic out, input logic [31:0] rd, input logic er);
        int   k;
        exp_t e;
        k = 0;
        sel[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
        while (!ready[d] && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL dut%0d_accept_timeout: ready=%b, expected 1 within 50 cycles", d, ready[d]);
        end
        if (out) begin
            e.rv = !w; e.rd = rd; e.er = er;
            push(d, e);
        end
        @(posedge clk); #1;
        sel[d] = 1'b0;
    endtask

    vec_t tv[22];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{1'b1, 8'h02, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0,         1'b0};
        tv[1]  = '{1'b0, 8'h02, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D, 1'b0};
        tv[2]  = '{1'b1, 8'h20, 32'h5555_5555, 4'hF, 1'b1, 32'h0,         1'b1};
        tv[3]  = '{1'b0, 8'h20, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1};
        tv[4]  = '{1'b1, 8'h0F, 32'h1234_5678, 4'h0, 1'b0, 32'h0,         1'b0};
        tv[5]  = '{1'b0, 8'h0F, 32'h0,         4'h0, 1'b1, RV_B,          1'b0};
        tv[6]  = '{1'b1, 8'h06, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0,         1'b1};
        tv[7]  = '{1'b0, 8'h06, 32'h0,         4'h0, 1'b1, RV_B,          1'b0};
        tv[8]  = '{1'b1, 8'h03, 32'h0102_0304, 4'h8, 1'b0, 32'h0,         1'b0};
        tv[9]  = '{1'b0, 8'h03, 32'h0,         4'h0, 1'b1, 32'h01AD_BEEF, 1'b0};
        tv[10] = '{1'b1, 8'h10, 32'h7777_7777, 4'hF, 1'b1, 32'h0,         1'b1};
        tv[11] = '{1'b0, 8'h10, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1};
        tv[12] = '{1'b1, 8'h08, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0,         1'b0};
        tv[13] = '{1'b0, 8'h08, 32'h0,         4'h0, 1'b1, 32'hA5A5_A5A5, 1'b0};
        tv[14] = '{1'b1, 8'h04, 32'h0,         4'hF, 1'b1, 32'h0,         1'b1};
        tv[15] = '{1'b0, 8'h04, 32'h0,         4'h0, 1'b1, RV_B,          1'b0};
        tv[16] = '{1'b1, 8'hF2, 32'h0,         4'hF, 1'b1, 32'h0,         1'b1};
        tv[17] = '{1'b1, 8'h01, 32'h1111_1111, 4'hF, 1'b0, 32'h0,         1'b0};
        tv[18] = '{1'b0, 8'h01, 32'h0,         4'h0, 1'b1, 32'h1111_1111, 1'b0};
        tv[19] = '{1'b0, 8'h02, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D, 1'b0};
        tv[20] = '{1'b0, 8'h03, 32'h0,         4'h0, 1'b1, 32'h01AD_BEEF, 1'b0};
        tv[21] = '{1'b0, 8'h07, 32'h0,         4'h0, 1'b1, RV_B,          1'b0};

        for (int d = 0; d < 3; d++) begin
            sel[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0; be[d] = '0;
        end

        // Reset state
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d_reset_ready", d),  32'(ready[d]),  32'h1);
            chk($sformatf("dut%0d_reset_rvalid", d), 32'(rvalid[d]), 32'h0);
            chk($sformatf("dut%0d_reset_rdata", d),  rdata[d],       32'h0);
            chk($sformatf("dut%0d_reset_err", d),    32'(err[d]),    32'h0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Latency-2 read of reset value: ready low for one cycle, then rvalid with ready
        drv(0, 1'b0, 8'h10, 32'h0, 4'h0, 1'b1, RV_A, 1'b0);
        @(negedge clk);
        chk("a_lat_ready_low", 32'(ready[0]), 32'h0);
        chk("a_lat_rvalid_early", 32'(rvalid[0]), 32'h0);
        @(negedge clk);
        chk("a_lat_ready_back", 32'(ready[0]), 32'h1);
        chk("a_lat_rvalid", 32'(rvalid[0]), 32'h1);
        @(posedge clk); #1;

        // Byte-enable merge with read-after-write on the next cycle
        drv(0, 1'b1, 8'h05, 32'h1122_3344, 4'hF, 1'b0, 32'h0, 1'b0);
        drv(0, 1'b1, 8'h05, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0, 1'b0);
        drv(0, 1'b0, 8'h05, 32'h0, 4'h0, 1'b1, 32'h11BB_33DD, 1'b0);
        drv(0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1, RV_A, 1'b0);
        repeat (4) @(posedge clk); #1;

        // Table vectors on the latency-1 / RO-window instance, one per cycle
        for (int i = 0; i < 22; i++) begin
            drv(1, tv[i].w, tv[i].a, tv[i].wd, tv[i].b, tv[i].out, tv[i].rd, tv[i].er);
            chk($sformatf("b_vec%0d_ready", i), 32'(ready[1]), 32'h1);
        end
        repeat (5) @(posedge clk); #1;

        // Reset one edge after a latency-4 read accept: read is dropped
        drv(2, 1'b1, 8'h09, 32'h9999_9999, 4'hF, 1'b0, 32'h0, 1'b0);
        drv(2, 1'b0, 8'h09, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
        chk("c_ready_after_accept", 32'(ready[2]), 32'h0);
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("c_ready_in_reset", 32'(ready[2]), 32'h1);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (8) @(posedge clk); #1;
        chk("c_ready_after_reset", 32'(ready[2]), 32'h1);

        // Register restored to reset value; latency-4 timing
        drv(2, 1'b0, 8'h09, 32'h0, 4'h0, 1'b1, RV_C, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("c_wait%0d_ready", k),  32'(ready[2]),  32'h0);
            chk($sformatf("c_wait%0d_rvalid", k), 32'(rvalid[2]), 32'h0);
        end
        @(negedge clk);
        chk("c_rvalid_lat4", 32'(rvalid[2]), 32'h1);
        chk("c_ready_lat4", 32'(ready[2]), 32'h1);
        @(posedge clk); #1;
        drv(0, 1'b0, 8'h05, 32'h0, 4'h0, 1'b1, RV_A, 1'b0);

        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("dut%0d_queue_drained", d), 32'(qsize(d)), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
